md5_block_loader: RTL

//  Write-side initiator for the single-port block RAM that holds one 512-bit MD5 message block.

---
 rtl/md5_pkg.sv | 18 +
 rtl/md5_block_loader_if.sv | 25 ++
 rtl/md5_byte_packer.sv | 42 ++++
 rtl/md5_block_loader.sv | 137 +++++++++++++
 4 files changed

// File: rtl/md5_pkg.sv
// rtl/md5_pkg.sv - shared MD5 block constants and loader state encoding
package md5_pkg;

  localparam logic [4:0] MD5_BLOCK_WORDS   = 5'd16;
  localparam logic [5:0] MD5_MAX_MSG_BYTES = 6'd55;
  localparam logic [7:0] MD5_PAD_BYTE      = 8'h80;
  localparam logic [3:0] MD5_LEN_WORD_LO   = 4'd14;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ACCEPT,
    ST_GAP,
    ST_PAD,
    ST_FIN,
    ST_ERR
  } loader_state_t;

endpackage

// File: rtl/md5_block_loader_if.sv
// rtl/md5_block_loader_if.sv - byte stream in, RAM write port out
interface md5_block_loader_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 4
);

  logic [7:0]            in_byte;
  logic                  in_valid;
  logic                  in_last;
  logic                  in_ready;
  logic [DATA_WIDTH-1:0] ram_data;
  logic [ADDR_WIDTH-1:0] ram_addr;
  logic                  ram_we;

  modport master (
    output in_byte, in_valid, in_last,
    input  in_ready, ram_data, ram_addr, ram_we
  );

  modport slave (
    input  in_byte, in_valid, in_last,
    output in_ready, ram_data, ram_addr, ram_we
  );

endinterface

// File: rtl/md5_byte_packer.sv
// rtl/md5_byte_packer.sv - little-endian byte-to-word packer
module md5_byte_packer (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_clear,
  input  logic        i_accept,
  input  logic [7:0]  i_byte,
  output logic [31:0] o_word_next,
  output logic [31:0] o_word,
  output logic [1:0]  o_lane,
  output logic        o_word_full
);

  logic [31:0] r_word;
  logic [1:0]  r_lane;
  logic [31:0] w_word_next;

  always_comb begin
    w_word_next = r_word;
    w_word_next[{r_lane, 3'b000} +: 8] = i_byte;
  end

  // A full word is handed off and cleared so a trailing partial word has zeros above its bytes.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_word <= '0;
      r_lane <= '0;
    end else if (i_clear) begin
      r_word <= '0;
      r_lane <= '0;
    end else if (i_accept) begin
      r_lane <= r_lane + 2'd1;
      r_word <= (r_lane == 2'd3) ? 32'd0 : w_word_next;
    end
  end

  assign o_word_next = w_word_next;
  assign o_word      = r_word;
  assign o_lane      = r_lane;
  assign o_word_full = i_accept & (r_lane == 2'd3);

endmodule

// File: rtl/md5_block_loader.sv
// rtl/md5_block_loader.sv - packs a byte message, pads it and writes one MD5 block to RAM
module md5_block_loader
  import md5_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 4,
  parameter int BASE_ADDR  = 0
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_start,
  md5_block_loader_if.slave  bus,
  output logic               o_busy,
  output logic               o_done,
  output logic               o_err
);

  localparam logic [ADDR_WIDTH-1:0] LP_BASE = ADDR_WIDTH'(BASE_ADDR);

  loader_state_t         r_state;
  logic                  r_in_ready;
  logic                  r_ram_we;
  logic [ADDR_WIDTH-1:0] r_ram_addr;
  logic [DATA_WIDTH-1:0] r_ram_data;
  logic                  r_busy;
  logic                  r_done;
  logic                  r_err;
  logic [5:0]            r_count;
  logic [4:0]            r_widx;

  logic        w_accept;
  logic        w_start_ok;
  logic [31:0] w_word_next;
  logic [31:0] w_word;
  logic [1:0]  w_lane;
  logic        w_word_full;
  logic [31:0] w_pad_word;
  logic [31:0] w_len_word;

  assign w_accept   = bus.in_valid & r_in_ready;
  assign w_start_ok = i_start & ((r_state == ST_IDLE) | (r_state == ST_ERR));
  assign w_pad_word = w_word | ({24'd0, MD5_PAD_BYTE} << {w_lane, 3'b000});
  assign w_len_word = {23'd0, r_count, 3'd0};

  md5_byte_packer u_packer (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_clear     (w_start_ok),
    .i_accept    (w_accept),
    .i_byte      (bus.in_byte),
    .o_word_next (w_word_next),
    .o_word      (w_word),
    .o_lane      (w_lane),
    .o_word_full (w_word_full)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= ST_IDLE;
      r_in_ready <= 1'b0;
      r_ram_we   <= 1'b0;
      r_ram_addr <= '0;
      r_ram_data <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
      r_count    <= '0;
      r_widx     <= '0;
    end else begin
      r_ram_we   <= 1'b0;
      r_ram_addr <= LP_BASE;
      r_ram_data <= '0;
      r_done     <= 1'b0;
      case (r_state)
        ST_IDLE, ST_ERR: begin
          if (w_start_ok) begin
            r_state    <= ST_ACCEPT;
            r_in_ready <= 1'b1;
            r_busy     <= 1'b1;
            r_err      <= 1'b0;
            r_count    <= '0;
          end
        end
        ST_ACCEPT: begin
          if (w_accept) begin
            r_count <= r_count + 6'd1;
            if (w_word_full) begin
              r_ram_we   <= 1'b1;
              r_ram_addr <= LP_BASE + ADDR_WIDTH'(r_count[5:2]);
              r_ram_data <= w_word_next;
            end
            if (bus.in_last) begin
              r_state    <= ST_GAP;
              r_in_ready <= 1'b0;
            end else if (r_count == MD5_MAX_MSG_BYTES - 6'd1) begin
              r_state    <= ST_ERR;
              r_in_ready <= 1'b0;
              r_busy     <= 1'b0;
              r_err      <= 1'b1;
            end
          end
        end
        // r_count now holds N; the first pad word merges any leftover message bytes.
        ST_GAP: begin
          r_ram_we   <= 1'b1;
          r_ram_addr <= LP_BASE + ADDR_WIDTH'(r_count[5:2]);
          r_ram_data <= w_pad_word;
          r_widx     <= {1'b0, r_count[5:2]} + 5'd1;
          r_state    <= ST_PAD;
        end
        ST_PAD: begin
          if (r_widx == MD5_BLOCK_WORDS) begin
            r_state <= ST_FIN;
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
          end else begin
            r_ram_we   <= 1'b1;
            r_ram_addr <= LP_BASE + ADDR_WIDTH'(r_widx[3:0]);
            r_ram_data <= (r_widx[3:0] == MD5_LEN_WORD_LO) ? w_len_word : 32'd0;
            r_widx     <= r_widx + 5'd1;
          end
        end
        ST_FIN:  r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.in_ready = r_in_ready;
  assign bus.ram_we   = r_ram_we;
  assign bus.ram_addr = r_ram_addr;
  assign bus.ram_data = r_ram_data;
  assign o_busy       = r_busy;
  assign o_done       = r_done;
  assign o_err        = r_err;

endmodule
